// File: rtl/core_load_unit.sv
// core_load_unit
//
// Per-core load sequencer. It takes a burst command (base address, word count)
// from a processing core and issues one storage request at a time. Each
// returned word is captured on the done pulse and parked in a small
// first-word-fall-through queue that the ALU drains through a valid/ready pair.
// If storage never answers a request, the burst is abandoned and a sticky
// timeout flag is raised.
//
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready     burst command handshake
//   cmd_base_addr, cmd_len    first word address and word count (0 = no-op)
//   storage_ce, storage_addr  one-cycle request pulse and its address
//   data_to_alu, done         returned word and its one-cycle completion pulse
//   out_valid / out_ready     queue head handshake toward the ALU
//   out_data, out_last        head word and end-of-burst marker
//   busy                      a burst is in progress
//   err_timeout               sticky: the last burst was aborted by timeout
module core_load_unit #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              storage_ce,
    output logic [ADDR_W-1:0] storage_addr,
    input  logic [DATA_W-1:0] data_to_alu,
    input  logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err_timeout
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [TMR_W-1:0]  timer_q;
    logic              err_q;

    logic [DATA_W-1:0] buf_data [BUF_DEPTH];
    logic              buf_last [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic accept;
    logic has_space;
    logic issue;
    logic push;
    logic pop;
    logic is_last;
    logic timed_out;

    // A request only goes out when the queue can take its answer, so a push
    // can never land on a full queue. Requests are also suppressed in the
    // reset cycle so an abort never lets one more pulse escape.
    assign cmd_ready = (state == S_IDLE) && !srst;
    assign accept    = cmd_valid && cmd_ready;
    assign has_space = count < DEPTH_C;
    assign issue     = (state == S_ISSUE) && has_space && !srst;
    assign push      = (state == S_WAIT) && done;
    assign pop       = out_valid && out_ready;
    assign is_last   = idx_q == (len_q - ADDR_W'(1));
    assign timed_out = (state == S_WAIT) && !done && (timer_q == TMR_LAST);

    // The address is base+idx; idx only advances on done, so it stays stable
    // through the whole wait for that word and wraps naturally at the top.
    assign storage_ce   = issue;
    assign storage_addr = base_q + idx_q;
    assign busy         = state != S_IDLE;
    assign err_timeout  = err_q;

    assign out_valid = count != '0;
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_last  = out_valid ? buf_last[rd_ptr] : 1'b0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept && (cmd_len != '0)) state_nxt = S_ISSUE;
            S_ISSUE: if (has_space) state_nxt = S_WAIT;
            S_WAIT: begin
                if (done) state_nxt = is_last ? S_IDLE : S_ISSUE;
                else if (timed_out) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The timer holds the number of cycles since the request pulse: it reads
    // 1 in the first wait cycle, so the abort decision is taken in the cycle
    // TIMEOUT-1 after the pulse and the flag shows TIMEOUT cycles after it.
    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_q <= cmd_base_addr;
                len_q  <= cmd_len;
                idx_q  <= '0;
                err_q  <= 1'b0;
            end
            if (issue) timer_q <= TMR_W'(1);
            else if (state == S_WAIT) timer_q <= timer_q + TMR_W'(1);
            else timer_q <= '0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                idx_q  <= idx_q + ADDR_W'(1);
            end
            if (timed_out) err_q <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= data_to_alu;
            buf_last[wr_ptr] <= is_last;
        end
    end

endmodule

// File: tb/tb_core_load_unit.sv
// tb_core_load_unit
//
// Drives core_load_unit with directed and randomized bursts. A storage
// responder answers requests after a chosen delay, and a transaction-level
// model predicts every cycle's handshake, address, flags and queue contents.
module tb_core_load_unit;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 4;
    localparam int TIMEOUT   = 255;

    logic              clk = 1'b0;
    logic              srst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_addr = '0;
    logic [ADDR_W-1:0] cmd_len = '0;
    logic              storage_ce;
    logic [ADDR_W-1:0] storage_addr;
    logic [DATA_W-1:0] data_to_alu = '0;
    logic              done = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err_timeout;

    always #5 clk = ~clk;

    core_load_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .srst(srst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len),
        .storage_ce(storage_ce), .storage_addr(storage_addr),
        .data_to_alu(data_to_alu), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } ent_t;

    int total = 0;
    int bad = 0;

    // Stimulus controls
    int         cyc = 0;
    bit         rst_req = 1'b1;
    bit         cmd_req = 1'b0;
    bit         force_done = 1'b0;
    logic [7:0] cmd_b = '0;
    logic [7:0] cmd_l = '0;
    int         resp_dmin = 1;
    int         resp_dmax = 1;
    int         resp_limit = 1000;
    int         ready_pct = 100;

    // Storage responder and observation tallies
    bit resp_pending = 1'b0;
    int resp_cycle = 0;
    int burst_ce = 0;
    int second_ce_cyc = 0;
    int err_rise_cyc = 0;
    bit prev_err = 1'b0;
    int ce_total = 0;
    int pop_total = 0;
    int last_total = 0;
    int acc_total = 0;
    int valid_total = 0;

    // Reference model: burst bookkeeping plus the expected queue contents
    bit         m_busy = 1'b0;
    bit         m_want = 1'b0;
    bit         m_pending = 1'b0;
    bit         m_err = 1'b0;
    logic [7:0] m_base = '0;
    logic [7:0] m_len = '0;
    logic [7:0] m_issued = '0;
    logic [7:0] m_returned = '0;
    int         m_ce_cycle = 0;
    ent_t       exp_out[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: compare outputs against the model, then drive this
    // cycle's inputs and advance the model to the following cycle.
    task automatic stepCycle();
        int         occ;
        bit         exp_ce;
        bit         accept_now;
        bit         lst;
        logic [7:0] a;
        @(posedge clk);
        #1;
        srst = rst_req;
        rst_req = 1'b0;
        #1;
        cyc++;
        occ = exp_out.size();

        checkOutput("cmd_ready", cmd_ready, !srst && !m_busy);
        checkOutput("busy", busy, m_busy);
        checkOutput("err_timeout", err_timeout, m_err);
        exp_ce = !srst && m_want && (occ < BUF_DEPTH);
        checkOutput("storage_ce", storage_ce, exp_ce);
        if (exp_ce) begin
            a = m_base + m_issued;
            checkOutput("ce_addr", storage_addr, a);
        end
        if (m_pending) begin
            a = m_base + m_issued - 8'd1;
            checkOutput("addr_hold", storage_addr, a);
        end
        checkOutput("out_valid", out_valid, occ != 0);
        out_ready = ($urandom_range(99, 0) < ready_pct);
        if (occ != 0) begin
            checkOutput("out_data", out_data, exp_out[0].data);
            checkOutput("out_last", out_last, exp_out[0].last);
        end

        if (out_valid) valid_total++;
        if (out_valid && out_ready) begin
            pop_total++;
            if (out_last) last_total++;
        end
        if (err_timeout && !prev_err) err_rise_cyc = cyc;
        prev_err = err_timeout;

        if (storage_ce) begin
            ce_total++;
            burst_ce++;
            if (burst_ce == 2) second_ce_cyc = cyc;
            if (burst_ce <= resp_limit) begin
                resp_pending = 1'b1;
                resp_cycle = cyc + int'($urandom_range(resp_dmax, resp_dmin));
            end
        end
        data_to_alu = $urandom;
        done = 1'b0;
        if (resp_pending && cyc == resp_cycle) begin
            done = 1'b1;
            resp_pending = 1'b0;
        end
        if (force_done) begin
            done = 1'b1;
            force_done = 1'b0;
        end

        cmd_valid = cmd_req;
        cmd_base_addr = cmd_b;
        cmd_len = cmd_l;
        if (cmd_valid && cmd_ready) acc_total++;
        accept_now = cmd_req && !srst && !m_busy;

        if (srst) begin
            m_busy = 1'b0;
            m_want = 1'b0;
            m_pending = 1'b0;
            m_err = 1'b0;
            exp_out.delete();
        end else begin
            if (occ != 0 && out_ready) void'(exp_out.pop_front());
            if (exp_ce) begin
                m_want = 1'b0;
                m_pending = 1'b1;
                m_ce_cycle = cyc;
                m_issued++;
            end
            if (done && m_pending && cyc > m_ce_cycle) begin
                lst = (m_returned == m_len - 8'd1);
                exp_out.push_back({lst, data_to_alu});
                m_returned++;
                m_pending = 1'b0;
                if (lst) m_busy = 1'b0;
                else m_want = 1'b1;
            end else if (m_pending && cyc == m_ce_cycle + TIMEOUT - 1) begin
                m_err = 1'b1;
                m_busy = 1'b0;
                m_pending = 1'b0;
            end
            if (accept_now) begin
                cmd_req = 1'b0;
                burst_ce = 0;
                m_base = cmd_b;
                m_len = cmd_l;
                m_issued = '0;
                m_returned = '0;
                m_err = 1'b0;
                if (cmd_l != 8'd0) begin
                    m_busy = 1'b1;
                    m_want = 1'b1;
                end
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while ((cmd_req || m_busy || exp_out.size() != 0 || resp_pending) && n < bound) begin
            stepCycle();
            n++;
        end
        if (n >= bound) checkOutput("wait_bound", 1, 0);
    endtask

    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] len,
                                 input int dmin, input int dmax, input int rdy);
        cmd_b = base;
        cmd_l = len;
        resp_dmin = dmin;
        resp_dmax = dmax;
        ready_pct = rdy;
        cmd_req = 1'b1;
    endtask

    initial begin
        int ce0;
        int p0;
        int l0;
        int a0;
        int v0;
        int n;

        // Reset state
        rst_req = 1'b1;
        stepCycle();
        rst_req = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst_addr", storage_addr, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_ready", cmd_ready, 1);

        // Single burst, fixed 2-cycle storage latency
        $display("[TB] single burst");
        ce0 = ce_total; p0 = pop_total; l0 = last_total;
        applyStimulus(8'h10, 8'd3, 2, 2, 100);
        waitIdle(200);
        checkOutput("s1_ce", ce_total - ce0, 3);
        checkOutput("s1_pops", pop_total - p0, 3);
        checkOutput("s1_last", last_total - l0, 1);

        // Address wrap with backpressure filling the queue
        $display("[TB] wrap and backpressure");
        ce0 = ce_total; p0 = pop_total;
        applyStimulus(8'hFE, 8'd6, 2, 2, 0);
        runCycles(30);
        checkOutput("s2_stall_ce", ce_total - ce0, 4);
        checkOutput("s2_stall_valid", out_valid, 1);
        ready_pct = 100;
        waitIdle(200);
        checkOutput("s2_ce", ce_total - ce0, 6);
        checkOutput("s2_pops", pop_total - p0, 6);

        // Zero-length command
        $display("[TB] zero length");
        ce0 = ce_total; a0 = acc_total; v0 = valid_total;
        applyStimulus(8'h33, 8'd0, 1, 1, 100);
        stepCycle();
        runCycles(10);
        checkOutput("s3_accept", acc_total - a0, 1);
        checkOutput("s3_ce", ce_total - ce0, 0);
        checkOutput("s3_valid", valid_total - v0, 0);

        // Timeout on the second request
        $display("[TB] timeout");
        ce0 = ce_total; p0 = pop_total; l0 = last_total;
        resp_limit = 1;
        applyStimulus(8'h20, 8'd4, 2, 2, 0);
        runCycles(TIMEOUT + 20);
        checkOutput("s4_err_latency", err_rise_cyc - second_ce_cyc, TIMEOUT);
        checkOutput("s4_err", err_timeout, 1);
        checkOutput("s4_ce", ce_total - ce0, 2);
        checkOutput("s4_valid", out_valid, 1);
        force_done = 1'b1;
        runCycles(5);
        resp_limit = 1000;
        ready_pct = 100;
        runCycles(5);
        checkOutput("s4_pops", pop_total - p0, 1);
        checkOutput("s4_last", last_total - l0, 0);
        applyStimulus(8'h50, 8'd2, 1, 3, 100);
        stepCycle();
        stepCycle();
        checkOutput("s4_err_clear", err_timeout, 0);
        waitIdle(200);

        // Spurious done while idle, then full-rate burst
        $display("[TB] spurious done and full rate");
        force_done = 1'b1;
        runCycles(3);
        p0 = pop_total; l0 = last_total;
        applyStimulus(8'h80, 8'd5, 1, 1, 100);
        waitIdle(200);
        checkOutput("s5_pops", pop_total - p0, 5);
        checkOutput("s5_last", last_total - l0, 1);

        // Reset while waiting with two words queued
        $display("[TB] reset mid-burst");
        applyStimulus(8'h40, 8'd5, 3, 3, 0);
        n = 0;
        while (!(exp_out.size() == 2 && m_pending) && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("s6_reach", n < 100, 1);
        rst_req = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("s6_valid", out_valid, 0);
        checkOutput("s6_busy", busy, 0);
        checkOutput("s6_ce", storage_ce, 0);
        checkOutput("s6_ready", cmd_ready, 1);
        ready_pct = 100;
        p0 = pop_total;
        runCycles(10);
        checkOutput("s6_pops", pop_total - p0, 0);

        // Randomized back-to-back bursts
        $display("[TB] random bursts");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom_range(255, 0)), 8'($urandom_range(9, 0)),
                          1, int'($urandom_range(5, 1)), int'($urandom_range(100, 30)));
            n = 0;
            while (cmd_req && n < 200) begin
                stepCycle();
                n++;
            end
        end
        waitIdle(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_load_unit.md
Name: core_load_unit

Overview:
- Per-core load sequencer on the core side of the 4-port storage data path.
- Accepts a burst command (base address, length) from a processing core.
- Issues one storage request at a time on a port's storage_ce/storage_addr, captures data_to_alu on each done pulse, and buffers the words in a small FWFT queue with a valid/ready interface toward the ALU.
- Aborts a burst with a sticky error if the storage side does not answer within a timeout.

Parameters:
- ADDR_W, 8, storage address width (matches storage_addr).
- DATA_W, 32, data word width (matches data_to_alu).
- BUF_DEPTH, 4, output queue depth in words (power of 2, >=2).
- TIMEOUT, 255, max cycles waited for done after a request (>=2).

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  unit can accept a command.
- cmd_base_addr  in  ADDR_W  first word address.
- cmd_len  in  ADDR_W  word count; 0 = no-op.
- storage_ce  out  1  one-cycle request pulse to the storage controller.
- storage_addr  out  ADDR_W  request address.
- data_to_alu  in  DATA_W  returned word, valid in the done cycle.
- done  in  1  one-cycle completion pulse from the storage controller.
- out_valid  out  1  head of queue valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_W  head word.
- out_last  out  1  head is the final word of its burst.
- busy  out  1  burst in progress (state != IDLE).
- err_timeout  out  1  sticky: the last burst was aborted by timeout.

Behaviour:
- Reset values (srst high at a clk edge): state IDLE; storage_ce=0; storage_addr=0; queue empty; out_valid=0; out_data=0; out_last=0; busy=0; err_timeout=0; word index and timer =0. cmd_ready=0 while srst is high.
- cmd_ready = (state==IDLE) & ~srst.
- A command is accepted when cmd_valid & cmd_ready.

FSM states: IDLE, ISSUE, WAIT.
- IDLE, on accept:
  - Latch base and len; clear err_timeout; idx=0.
  - If len==0, stay in IDLE: nothing issued, nothing queued.
  - Otherwise go to ISSUE.
- ISSUE:
  - If the queue count < BUF_DEPTH: storage_ce=1 for exactly this cycle, storage_addr=(base+idx) mod 2^ADDR_W (wraps 255->0), timer=0, go to WAIT.
  - Otherwise stall in ISSUE with ce=0.
- WAIT:
  - storage_addr is held stable; timer increments each cycle.
  - On done: push {data_to_alu, last=(idx==len-1)} into the queue; idx++.
    - If last, go to IDLE.
    - Otherwise go to ISSUE.
  - If no done when timer==TIMEOUT-1: set err_timeout, drop the remaining words, go to IDLE. Words already queued stay queued; no out_last is produced for the aborted burst.

Issue and timing rules:
- At most one outstanding request. Issue is gated by queue space, so a push never meets a full queue.
- done outside WAIT (late after timeout, spurious, or after reset) is ignored with no push.
- Latency: command accepted at cycle T -> storage_ce at T+1. done at cycle D -> out_valid visible at D+1. The next storage_ce is at D+1 if there is space.
- Back-to-back bursts: the next command can be accepted in the cycle after the last done, while the queue still drains.

Queue:
- FWFT; pop when out_valid & out_ready.
- A simultaneous push and pop leaves the count unchanged and preserves order.
- out_data and out_last are held stable while out_valid & ~out_ready.

Reset mid-burst: srst aborts immediately. The queue is flushed, no further storage_ce is issued, and err_timeout is cleared.

Test Plan:
- Single burst, base=0x10, len=3, done 2 cycles after each ce, out_ready=1 -> storage_addr 0x10, 0x11, 0x12, one ce each. out_data equals the returned words in order; out_last=1 only on the third word; busy falls after the third done.
- Wrap and backpressure, base=0xFE, len=6, BUF_DEPTH=4, out_ready=0 -> addresses 0xFE, 0xFF, 0x00, 0x01. storage_ce stalls after 4 words with out_valid=1 and the head held stable. With out_ready raised, addresses 0x02 and 0x03 are issued and all 6 words exit in order.
- len=0 command -> accepted (cmd_ready high in the accept cycle); no storage_ce and no out_valid in the following 10 cycles.
- Timeout, base=0x20, len=4, done withheld after the 2nd request -> storage_ce stays 0 and err_timeout=1 exactly TIMEOUT cycles after that ce; 1 word is queued; a later done is ignored; the next command clears err_timeout.
- Spurious done in IDLE plus simultaneous push/pop at full rate (done every cycle after ce, out_ready=1) -> no extra queue entries; occupancy never exceeds 1.
- srst pulsed while in WAIT with 2 words queued -> the next cycle has out_valid=0, busy=0, storage_ce=0, cmd_ready=1; a done arriving after reset produces no output.
